// File: rtl/icap_pkg.sv
// Shared ICAP definitions for the Spartan-6 configuration reader and the
// multiboot writer. Holds the command-word constants, the reader state
// encoding, the command-ROM phase selector and the byte-wise bit reversal
// used on the ICAP data pins.
package icap_pkg;

  localparam logic [15:0] ICAP_DUMMY       = 16'hFFFF;
  localparam logic [15:0] ICAP_SYNC0       = 16'hAA99;
  localparam logic [15:0] ICAP_SYNC1       = 16'h5566;
  localparam logic [15:0] ICAP_NOOP        = 16'h2000;
  localparam logic [15:0] ICAP_CMD_WR_HDR  = 16'h30A1;  // type-1 write to CMD, 1 word
  localparam logic [15:0] ICAP_CMD_DESYNC  = 16'h000D;
  localparam logic [15:0] ICAP_RD_HDR_BASE = 16'h2801;  // type-1 read, word count 1

  typedef enum logic [2:0] {
    IDLE,
    WR_SEQ,
    TURN_RD,
    READ_WAIT,
    TURN_WR,
    DESYNC_SEQ,
    DONE
  } icap_state_e;

  typedef enum logic {
    PH_RD_CMD,
    PH_DESYNC
  } rom_phase_e;

  // ICAP_SPARTAN6 expects bit 0 of every byte on the MSB of that byte.
  function automatic logic [15:0] bitswap16(input logic [15:0] w);
    logic [15:0] r;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 8; i++) begin
        r[8*b + i] = w[8*b + 7 - i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/icap_word_rom.sv
// Command-word ROM for the ICAP reader.
// Ports:
//   phase - PH_RD_CMD selects the sync + read-header sequence,
//           PH_DESYNC selects the trailing desync sequence
//   idx   - word index within the selected sequence
//   addr  - configuration register address merged into the read header
//   word  - unswapped command word for that slot
module icap_word_rom
  import icap_pkg::*;
(
  input  rom_phase_e  phase,
  input  logic [2:0]  idx,
  input  logic [5:0]  addr,
  output logic [15:0] word
);

  always_comb begin
    word = ICAP_NOOP;
    if (phase == PH_RD_CMD) begin
      case (idx)
        3'd0:    word = ICAP_DUMMY;
        3'd1:    word = ICAP_SYNC0;
        3'd2:    word = ICAP_SYNC1;
        3'd3:    word = ICAP_NOOP;
        3'd4:    word = ICAP_RD_HDR_BASE | {5'b0, addr, 5'b0};
        default: word = ICAP_NOOP;
      endcase
    end else begin
      case (idx)
        3'd0:    word = ICAP_CMD_WR_HDR;
        3'd1:    word = ICAP_CMD_DESYNC;
        default: word = ICAP_NOOP;
      endcase
    end
  end

endmodule

// File: rtl/icap_config_reader.sv
// Reads one Spartan-6 configuration register back through raw ICAP pins:
// sync, read header, NOOPs, bus turnaround, one captured word, turnaround,
// desync. A thin wrapper connects the icap_* pins to ICAP_SPARTAN6.
// Ports:
//   clk_icap  - ICAP clock (<= 20 MHz), the only clock
//   resetn    - synchronous active-low reset
//   req       - start pulse, honoured only while ready=1
//   reg_addr  - 6-bit register address, latched on an accepted req
//   ready     - idle / able to accept req
//   rd_valid  - one-cycle pulse, rd_data valid
//   rd_data   - captured register word, held until the next capture
//   timeout   - asserted with rd_valid when busy never dropped (rd_data=0)
//   icap_ce_n, icap_wr_n, icap_din, icap_dout, icap_busy - raw ICAP pins
module icap_config_reader
  import icap_pkg::*;
#(
  parameter bit          BIT_SWAP       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_icap,
  input  logic        resetn,
  input  logic        req,
  input  logic [5:0]  reg_addr,
  output logic        ready,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        timeout,
  output logic        icap_ce_n,
  output logic        icap_wr_n,
  output logic [15:0] icap_din,
  input  logic [15:0] icap_dout,
  input  logic        icap_busy
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  icap_state_e state, state_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [7:0]  wait_cnt, wait_nxt;
  logic [5:0]  addr_q;
  logic        abort_q;
  logic [15:0] rd_data_q;
  logic        accept, capture, abort_set;
  rom_phase_e  phase;
  logic [15:0] rom_word;

  assign ready    = (state == IDLE) || (state == DONE);
  assign accept   = ready && req;
  assign rd_valid = (state == DONE);
  assign timeout  = (state == DONE) && abort_q;
  assign rd_data  = rd_data_q;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wait_nxt  = wait_cnt;
    capture   = 1'b0;
    abort_set = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = WR_SEQ;
          idx_nxt   = 3'd0;
        end
      end
      WR_SEQ: begin
        if (idx == 3'd6) begin
          state_nxt = TURN_RD;
          idx_nxt   = 3'd0;
        end else begin
          idx_nxt = idx + 3'd1;
        end
      end
      TURN_RD: begin
        if (idx == 3'd1) begin
          state_nxt = READ_WAIT;
          idx_nxt   = 3'd0;
          wait_nxt  = 8'd0;
        end else begin
          idx_nxt = idx + 3'd1;
        end
      end
      READ_WAIT: begin
        wait_nxt = wait_cnt + 8'd1;
        // Cycle 0 of the read window is still in the ICAP output pipeline.
        if ((wait_cnt != 8'd0) && !icap_busy) begin
          capture   = 1'b1;
          state_nxt = TURN_WR;
          idx_nxt   = 3'd0;
        end else if (wait_cnt == WAIT_LAST) begin
          abort_set = 1'b1;
          state_nxt = TURN_WR;
          idx_nxt   = 3'd0;
        end
      end
      TURN_WR: begin
        if (idx == 3'd1) begin
          state_nxt = DESYNC_SEQ;
          idx_nxt   = 3'd0;
        end else begin
          idx_nxt = idx + 3'd1;
        end
      end
      DESYNC_SEQ: begin
        if (idx == 3'd3) begin
          state_nxt = DONE;
          idx_nxt   = 3'd0;
        end else begin
          idx_nxt = idx + 3'd1;
        end
      end
      DONE: begin
        // ready is high here, so a waiting req starts the next read at once.
        state_nxt = req ? WR_SEQ : IDLE;
        idx_nxt   = 3'd0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_icap) begin
    if (!resetn) begin
      state     <= IDLE;
      idx       <= 3'd0;
      wait_cnt  <= 8'd0;
      abort_q   <= 1'b0;
      rd_data_q <= 16'h0000;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      wait_cnt <= wait_nxt;
      if (accept) begin
        abort_q <= 1'b0;
      end else if (abort_set) begin
        abort_q <= 1'b1;
      end
      if (capture) begin
        rd_data_q <= BIT_SWAP ? bitswap16(icap_dout) : icap_dout;
      end else if (abort_set) begin
        rd_data_q <= 16'h0000;
      end
    end
  end

  always_ff @(posedge clk_icap) begin
    if (accept) begin
      addr_q <= reg_addr;
    end
  end

  // Pin decode. Each turnaround moves CE first and WRITE one cycle later,
  // so the two never toggle on the same edge.
  always_comb begin
    icap_ce_n = 1'b1;
    icap_wr_n = 1'b0;
    phase     = PH_RD_CMD;
    case (state)
      WR_SEQ:     icap_ce_n = 1'b0;
      TURN_RD:    icap_wr_n = (idx != 3'd0);
      READ_WAIT: begin
        icap_ce_n = 1'b0;
        icap_wr_n = 1'b1;
      end
      TURN_WR:    icap_wr_n = (idx == 3'd0);
      DESYNC_SEQ: begin
        icap_ce_n = 1'b0;
        phase     = PH_DESYNC;
      end
      default: ;
    endcase
  end

  icap_word_rom u_rom (
    .phase (phase),
    .idx   (idx),
    .addr  (addr_q),
    .word  (rom_word)
  );

  assign icap_din = icap_ce_n ? 16'hFFFF :
                    (BIT_SWAP ? bitswap16(rom_word) : rom_word);

endmodule
